noc_out_port: RTL and testbench

//  Output stage of a mesh router. Pops flits from the router FIFO that the input

---
 rtl/noc_out_port_pkg.sv | 26 ++
 rtl/noc_xy_route.sv | 25 ++
 rtl/noc_out_port.sv | 125 ++++++++++++
 tb/tb_noc_out_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_out_port_pkg.sv
// rtl/noc_out_port_pkg.sv - shared router definitions: direction indices, port FSM states, flit field offsets
package noc_out_port_pkg;

  localparam logic [2:0] DIR_W = 3'd0;
  localparam logic [2:0] DIR_S = 3'd1;
  localparam logic [2:0] DIR_E = 3'd2;
  localparam logic [2:0] DIR_N = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;
  localparam int NUM_DIRS = 5;

  localparam int FLIT_TAIL_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_REQ  = 3'd3,
    ST_ACK  = 3'd4
  } port_state_t;

  // Destination X sits at the bottom of the flit, destination Y directly above it.
  function automatic int dest_y_lsb(input int coord_w);
    return coord_w;
  endfunction

endpackage

// File: rtl/noc_xy_route.sv
// rtl/noc_xy_route.sv - dimension-ordered XY route: resolve X first, then Y, else deliver locally
module noc_xy_route
  import noc_out_port_pkg::*;
#(
  parameter int COORD_W = 1,
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output logic [2:0]         dir
);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORD);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORD);

  always_comb begin
    dir = DIR_L;
    if (dest_x > MY_X)      dir = DIR_E;
    else if (dest_x < MY_X) dir = DIR_W;
    else if (dest_y > MY_Y) dir = DIR_N;
    else if (dest_y < MY_Y) dir = DIR_S;
  end

endmodule

// File: rtl/noc_out_port.sv
// rtl/noc_out_port.sv - router output stage: pops FIFO flits and delivers them over 4-phase req/ack
module noc_out_port
  import noc_out_port_pkg::*;
#(
  parameter int DATA_WIDTH = 37,
  parameter int COORD_W    = 1,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int TAIL_BIT   = FLIT_TAIL_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_empty,
  output logic                  fifo_rdreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  Outr_L,
  output logic                  Outr_N,
  output logic                  Outr_E,
  output logic                  Outr_S,
  output logic                  Outr_W,
  input  logic                  Outw_L,
  input  logic                  Outw_N,
  input  logic                  Outw_E,
  input  logic                  Outw_S,
  input  logic                  Outw_W
);

  localparam int DY_LSB = dest_y_lsb(COORD_W);

  port_state_t           state_q, state_d;
  logic                  rdreq_q, rdreq_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_DIRS-1:0]   outr_q, outr_d;
  logic [2:0]            dir_q, dir_d;
  logic                  locked_q, locked_d;
  logic                  tail_q, tail_d;
  logic [2:0]            route_dir;
  logic [2:0]            dir_use;
  logic [NUM_DIRS-1:0]   outw_vec;

  assign outw_vec = {Outw_L, Outw_N, Outw_E, Outw_S, Outw_W};

  noc_xy_route #(
    .COORD_W (COORD_W),
    .X_COORD (X_COORD),
    .Y_COORD (Y_COORD)
  ) u_route (
    .dest_x (fifo_q[COORD_W-1:0]),
    .dest_y (fifo_q[DY_LSB +: COORD_W]),
    .dir    (route_dir)
  );

  // Body and tail flits follow the head's direction; their address bits are payload.
  assign dir_use = locked_q ? dir_q : route_dir;

  always_comb begin
    state_d  = state_q;
    rdreq_d  = 1'b0;
    data_d   = data_q;
    outr_d   = outr_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    tail_d   = tail_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rdreq_d = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_LOAD;
      ST_LOAD: begin
        data_d   = fifo_q;
        tail_d   = fifo_q[TAIL_BIT];
        dir_d    = dir_use;
        locked_d = 1'b1;
        outr_d   = NUM_DIRS'(1) << dir_use;
        state_d  = ST_REQ;
      end
      ST_REQ: begin
        if (outw_vec[dir_q]) begin
          outr_d  = '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!outw_vec[dir_q]) begin
          if (tail_q) locked_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rdreq_q  <= 1'b0;
      data_q   <= '0;
      outr_q   <= '0;
      dir_q    <= DIR_W;
      locked_q <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdreq_q  <= rdreq_d;
      data_q   <= data_d;
      outr_q   <= outr_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      tail_q   <= tail_d;
    end
  end

  assign fifo_rdreq = rdreq_q;
  assign data_out   = data_q;
  assign Outr_W     = outr_q[DIR_W];
  assign Outr_S     = outr_q[DIR_S];
  assign Outr_E     = outr_q[DIR_E];
  assign Outr_N     = outr_q[DIR_N];
  assign Outr_L     = outr_q[DIR_L];

endmodule

// File: tb/tb_noc_out_port.sv
// tb/tb_noc_out_port.sv - directed bench for noc_out_port with a packet-level scoreboard
module tb_noc_out_port;

  localparam int DW = 37;
  localparam int MX = 0;
  localparam int MY = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic [DW-1:0] data_out;
  logic Outr_L, Outr_N, Outr_E, Outr_S, Outr_W;
  logic Outw_L, Outw_N, Outw_E, Outw_S, Outw_W;

  always #5 clk = ~clk;

  noc_out_port #(
    .DATA_WIDTH (DW), .COORD_W (1), .X_COORD (MX), .Y_COORD (MY), .TAIL_BIT (4)
  ) dut (
    .clk (clk), .reset (reset), .fifo_q (fifo_q), .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq), .data_out (data_out),
    .Outr_L (Outr_L), .Outr_N (Outr_N), .Outr_E (Outr_E), .Outr_S (Outr_S), .Outr_W (Outr_W),
    .Outw_L (Outw_L), .Outw_N (Outw_N), .Outw_E (Outw_E), .Outw_S (Outw_S), .Outw_W (Outw_W)
  );

  int n_vec = 0;
  int n_bad = 0;

  // FIFO stand-in: written only by the stimulus, popped only by the DUT.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rdreq && rd_ptr != wr_ptr) begin
      fifo_q <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Neighbours: raise ack ack_delay cycles after seeing req, drop it once req falls.
  wire [4:0] outr = {Outr_L, Outr_N, Outr_E, Outr_S, Outr_W};
  logic [4:0] resp = '0;
  int ack_delay = 0;
  int cnt [5] = '{0, 0, 0, 0, 0};
  logic force_n = 1'b0;
  logic noise_s = 1'b0;
  assign Outw_W = resp[0];
  assign Outw_S = resp[1] | noise_s;
  assign Outw_E = resp[2];
  assign Outw_N = resp[3] | force_n;
  assign Outw_L = resp[4];
  wire [4:0] outw = {Outw_L, Outw_N, Outw_E, Outw_S, Outw_W};

  always @(posedge clk) begin
    for (int d = 0; d < 5; d++) begin
      if (outr[d]) begin
        cnt[d] <= cnt[d] + 1;
        if (cnt[d] + 1 > ack_delay) resp[d] <= 1'b1;
      end else begin
        cnt[d]  <= 0;
        resp[d] <= 1'b0;
      end
    end
  end

  // Packet-level model: each pushed flit gets its direction from XY routing on heads,
  // and inherits the packet's direction otherwise.
  logic [DW-1:0] exp_data [$];
  int            exp_dir  [$];
  logic [DW-1:0] log_data [$];
  int            log_dir  [$];
  bit m_head = 1'b1;
  int m_dir = 0;

  function automatic int xy_dir(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[0]);
    dy = int'(f[1]);
    if (dx > MX) return 2;
    if (dx < MX) return 0;
    if (dy > MY) return 3;
    if (dy < MY) return 1;
    return 4;
  endfunction

  task automatic push(input logic [DW-1:0] f);
    if (m_head) m_dir = xy_dir(f);
    exp_data.push_back(f);
    exp_dir.push_back(m_dir);
    m_head = f[4];
    mem[wr_ptr % 64] = f;
    wr_ptr = wr_ptr + 1;
  endtask

  // Compare process: checks every cycle against the current expected flit.
  logic [DW-1:0] cur_data = '0;
  int  cur_dir = 0;
  bit  in_flight = 1'b0;
  logic [4:0] prev_outr = '0;
  logic prev_rdreq = 1'b0;
  int  n_pops = 0;

  always @(negedge clk) begin
    if (reset) begin
      n_vec++;
      if ($countones(outr) > 1) begin
        n_bad++; $display("FAIL onehot: outr=%b required at most one bit", outr);
      end
      if (fifo_rdreq) begin
        n_pops++;
        n_vec++;
        if (fifo_empty || outr != 0 || prev_rdreq || in_flight) begin
          n_bad++;
          $display("FAIL rdreq_legal: empty=%b outr=%b prev_rdreq=%b busy=%b required 0,0,0,0",
                   fifo_empty, outr, prev_rdreq, in_flight);
        end
      end
      if (outr != 0 && prev_outr == 0) begin
        n_vec++;
        if (exp_data.size() == 0) begin
          n_bad++; $display("FAIL unexpected_flit: data=%h outr=%b required no request", data_out, outr);
        end else begin
          cur_data = exp_data.pop_front();
          cur_dir  = exp_dir.pop_front();
          in_flight = 1'b1;
          log_data.push_back(data_out);
          log_dir.push_back($clog2(int'(outr)));
        end
      end
      if (outr != 0 && in_flight) begin
        n_vec++;
        if (outr != (5'd1 << cur_dir) || data_out != cur_data) begin
          n_bad++;
          $display("FAIL deliver: outr=%b data=%h required outr=%b data=%h",
                   outr, data_out, 5'd1 << cur_dir, cur_data);
        end
      end else if (outr == 0 && in_flight) begin
        if (outw[cur_dir]) begin
          n_vec++;
          if (data_out != cur_data) begin
            n_bad++; $display("FAIL hold_until_ack_low: data=%h required %h", data_out, cur_data);
          end
        end else begin
          in_flight = 1'b0;
        end
      end
    end
    prev_outr  = outr;
    prev_rdreq = fifo_rdreq;
  end

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_data.size() != 0 || in_flight || outr != 0 || !fifo_empty) && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (exp_data.size() != 0 || in_flight || outr != 0 || fifo_rdreq) begin
      n_bad++;
      $display("FAIL drain_%s: pending=%0d outr=%b rdreq=%b required 0,0,0",
               name, exp_data.size(), outr, fifo_rdreq);
    end
  endtask

  task automatic expect_lit(input string name, input int idx, input int dir, input logic [DW-1:0] data);
    n_vec++;
    if (idx >= log_dir.size()) begin
      n_bad++; $display("FAIL %s: delivery %0d missing, required dir %0d", name, idx, dir);
    end else if (log_dir[idx] != dir || log_data[idx] != data) begin
      n_bad++;
      $display("FAIL %s: dir=%0d data=%h required dir=%0d data=%h",
               name, log_dir[idx], log_data[idx], dir, data);
    end
  endtask

  initial begin
    int pops0;
    int base;
    // Reset held with a queued flit and a stray North ack.
    push(37'h12);
    force_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_vec++;
      if (fifo_rdreq !== 1'b0 || outr !== 5'b0 || data_out !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: rdreq=%b outr=%b data=%h required 0", fifo_rdreq, outr, data_out);
      end
    end
    force_n = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Single-flit packet to North, ack after two cycles.
    ack_delay = 2;
    drain("single", 60);
    expect_lit("single_north", 0, 3, 37'h12);
    n_vec++;
    if (n_pops != 1) begin
      n_bad++; $display("FAIL single_pops: pops=%0d required 1", n_pops);
    end

    // Three-flit packet locked to East.
    ack_delay = 0;
    pops0 = n_pops;
    base = log_dir.size();
    push(37'h01); push(37'h20); push(37'h10);
    drain("three", 100);
    expect_lit("three_head", base, 2, 37'h01);
    expect_lit("three_body", base + 1, 2, 37'h20);
    expect_lit("three_tail", base + 2, 2, 37'h10);
    n_vec++;
    if (n_pops - pops0 != 3) begin
      n_bad++; $display("FAIL three_pops: pops=%0d required 3", n_pops - pops0);
    end

    // Local delivery, then a fresh head re-routes to East.
    base = log_dir.size();
    push(37'h10); push(37'h11);
    drain("relock", 100);
    expect_lit("local", base, 4, 37'h10);
    expect_lit("after_tail_east", base + 1, 2, 37'h11);

    // South ack noise while a slow East handshake is outstanding.
    ack_delay = 6;
    push(37'h15);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      noise_s = ~noise_s;
      if (i == 6) begin
        n_vec++;
        if (outr != 5'b00100 || data_out != 37'h15) begin
          n_bad++;
          $display("FAIL noise_hold: outr=%b data=%h required 00100 %h", outr, data_out, 37'h15);
        end
      end
    end
    noise_s = 1'b0;
    ack_delay = 1;
    drain("noise", 80);

    // FIFO runs dry mid-packet; the body and tail must still go East.
    base = log_dir.size();
    push(37'h01);
    drain("gap_head", 60);
    repeat (6) begin
      @(posedge clk); #1;
      n_vec++;
      if (fifo_rdreq || outr != 0) begin
        n_bad++; $display("FAIL gap_idle: rdreq=%b outr=%b required 0", fifo_rdreq, outr);
      end
    end
    push(37'h22); push(37'h13);
    drain("gap_rest", 100);
    push(37'h12);
    drain("gap_next", 60);
    expect_lit("gap_head", base, 2, 37'h01);
    expect_lit("gap_body", base + 1, 2, 37'h22);
    expect_lit("gap_tail", base + 2, 2, 37'h13);
    expect_lit("gap_next_north", base + 3, 3, 37'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
